// File: rtl/mini_cpu_datapath_if.sv
// Bus between the CPU control sequencer (master) and the datapath (slave).
// Carries phase/opcode/operand controls in, and registered operands, result and phase-done flags out.
interface mini_cpu_datapath_if;
  logic [2:0]  state_cpu;
  logic [2:0]  opcode;
  logic [3:0]  addr1;
  logic [3:0]  addr2;
  logic [3:0]  addr3;
  logic        sinal_imm;
  logic [5:0]  imm;
  logic [15:0] v1_ram;
  logic [15:0] v2_ram;
  logic [15:0] result;
  logic        decoded;
  logic        read;
  logic        calculated;
  logic        stored;

  modport master (
    output state_cpu, opcode, addr1, addr2, addr3, sinal_imm, imm,
    input  v1_ram, v2_ram, result, decoded, read, calculated, stored
  );

  modport slave (
    input  state_cpu, opcode, addr1, addr2, addr3, sinal_imm, imm,
    output v1_ram, v2_ram, result, decoded, read, calculated, stored
  );
endinterface

// File: rtl/mini_cpu_datapath.sv
// 16x16 register file + ALU stepped by an external CPU phase; every phase acts on its first edge (1 cycle), no backpressure.
// Optional multiplier enabled by defining DATAPATH_MUL_EN; otherwise MUL yields 0 and skips the write.
module mini_cpu_datapath (
  input  logic                  clk,
  input  logic                  rst_n,
  mini_cpu_datapath_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'b000,
    ST_FETCH  = 3'b001,
    ST_DECODE = 3'b010,
    ST_READ   = 3'b011,
    ST_CALC   = 3'b100,
    ST_SHOW   = 3'b101,
    ST_STORE  = 3'b110,
    ST_RSVD   = 3'b111
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD    = 3'b000,
    OP_ADD     = 3'b001,
    OP_ADDI    = 3'b010,
    OP_SUB     = 3'b011,
    OP_SUBI    = 3'b100,
    OP_MUL     = 3'b101,
    OP_CLEAR   = 3'b110,
    OP_DISPLAY = 3'b111
  } opcode_t;

  state_t      state;
  opcode_t     op;
  logic [15:0] mem [16];
  logic [15:0] v1_q;
  logic [15:0] v2_q;
  logic [15:0] result_q;
  logic        decoded_q;
  logic        read_q;
  logic        calc_q;
  logic        stored_q;
  logic [15:0] imm_ext;
  logic [15:0] imm_val;
  logic [15:0] alu;
  logic        wr_en;

  assign state   = state_t'(bus.state_cpu);
  assign op      = opcode_t'(bus.opcode);
  assign imm_ext = {10'd0, bus.imm};
  assign imm_val = bus.sinal_imm ? (16'd0 - imm_ext) : imm_ext;

  always_comb begin
    alu = '0;
    case (op)
      OP_LOAD:    alu = imm_val;
      OP_ADD:     alu = v1_q + v2_q;
      OP_ADDI:    alu = v1_q + imm_val;
      OP_SUB:     alu = v1_q - v2_q;
      OP_SUBI:    alu = v1_q - imm_val;
`ifdef DATAPATH_MUL_EN
      OP_MUL:     alu = v1_q * v2_q;
`else
      OP_MUL:     alu = '0;
`endif
      OP_CLEAR:   alu = '0;
      OP_DISPLAY: alu = v1_q;
      default:    alu = '0;
    endcase
  end

  // Single-entry write: CLEAR and DISPLAY are handled separately, MUL only with the multiplier built.
  always_comb begin
    wr_en = 1'b0;
    case (op)
      OP_LOAD, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: wr_en = 1'b1;
`ifdef DATAPATH_MUL_EN
      OP_MUL:  wr_en = 1'b1;
`endif
      default: wr_en = 1'b0;
    endcase
  end

  // Each flag doubles as the "already executed this visit" marker, so a held state acts only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      v1_q      <= '0;
      v2_q      <= '0;
      result_q  <= '0;
      decoded_q <= 1'b0;
      read_q    <= 1'b0;
      calc_q    <= 1'b0;
      stored_q  <= 1'b0;
    end else begin
      decoded_q <= (state == ST_DECODE);
      read_q    <= (state == ST_READ);
      calc_q    <= (state == ST_CALC);
      stored_q  <= (state == ST_STORE);

      if (state == ST_READ && !read_q) begin
        if (op == OP_DISPLAY) begin
          v1_q <= mem[bus.addr1];
          v2_q <= '0;
        end else begin
          v1_q <= mem[bus.addr2];
          v2_q <= mem[bus.addr3];
        end
      end

      if (state == ST_CALC && !calc_q) result_q <= alu;

      if (state == ST_STORE && !stored_q) begin
        if (op == OP_CLEAR) begin
          for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (wr_en) begin
          mem[bus.addr1] <= result_q;
        end
      end
    end
  end

  assign bus.v1_ram     = v1_q;
  assign bus.v2_ram     = v2_q;
  assign bus.result     = result_q;
  assign bus.decoded    = decoded_q;
  assign bus.read       = read_q;
  assign bus.calculated = calc_q;
  assign bus.stored     = stored_q;

endmodule

// File: tb/tb_mini_cpu_datapath.sv
// Directed bench for mini_cpu_datapath: each task drives one scenario and checks hand-computed values.
module tb_mini_cpu_datapath;

  localparam logic [2:0] S_OFF = 3'b000, S_FETCH = 3'b001, S_DECODE = 3'b010, S_READ = 3'b011;
  localparam logic [2:0] S_CALC = 3'b100, S_SHOW = 3'b101, S_STORE = 3'b110;
  localparam logic [2:0] LOAD = 3'b000, ADD = 3'b001, ADDI = 3'b010, SUB = 3'b011;
  localparam logic [2:0] SUBI = 3'b100, MUL = 3'b101, CLEAR = 3'b110, DISP = 3'b111;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mini_cpu_datapath_if bus ();

  mini_cpu_datapath dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set state on the falling edge, let n rising edges pass, sample 1 time unit later.
  task automatic phase(input logic [2:0] st, input int n);
    @(negedge clk);
    bus.state_cpu = st;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] op, input logic [3:0] a1, input logic [3:0] a2,
                            input logic [3:0] a3, input logic s, input logic [5:0] im);
    bus.opcode    = op;
    bus.addr1     = a1;
    bus.addr2     = a2;
    bus.addr3     = a3;
    bus.sinal_imm = s;
    bus.imm       = im;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic [3:0] a1, input logic [3:0] a2,
                           input logic [3:0] a3, input logic s, input logic [5:0] im);
    set_fields(op, a1, a2, a3, s, im);
    phase(S_FETCH, 1);
    phase(S_DECODE, 1);
    phase(S_READ, 1);
    phase(S_CALC, 1);
    phase(S_STORE, 1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({bus.v1_ram, bus.v2_ram, bus.result} !== 48'd0) begin
      failures++;
      $display("FAIL reset_data: got %h %h %h, want 0 0 0", bus.v1_ram, bus.v2_ram, bus.result);
    end
    checks++;
    if ({bus.decoded, bus.read, bus.calculated, bus.stored} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b, want 0000", {bus.decoded, bus.read, bus.calculated, bus.stored});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(DISP, 4'd5, 4'd0, 4'd0, 1'b0, 6'd0);
    checks++;
    if (bus.v1_ram !== 16'd0) begin
      failures++;
      $display("FAIL reset_mem_r5: got %h, want 0000", bus.v1_ram);
    end
  endtask

  task automatic test_load;
    set_fields(LOAD, 4'd3, 4'd0, 4'd0, 1'b0, 6'd25);
    phase(S_FETCH, 1);
    checks++;
    if (bus.decoded !== 1'b0) begin failures++; $display("FAIL load_fetch_decoded: got %b, want 0", bus.decoded); end
    phase(S_DECODE, 1);
    checks++;
    if (bus.decoded !== 1'b1) begin failures++; $display("FAIL load_decoded: got %b, want 1", bus.decoded); end
    phase(S_READ, 1);
    checks++;
    if ({bus.decoded, bus.read} !== 2'b01) begin failures++; $display("FAIL load_read: got %b, want 01", {bus.decoded, bus.read}); end
    phase(S_CALC, 1);
    checks++;
    if (bus.calculated !== 1'b1 || bus.result !== 16'h0019) begin
      failures++; $display("FAIL load_calc: got flag %b result %h, want 1 0019", bus.calculated, bus.result);
    end
    phase(S_STORE, 1);
    checks++;
    if ({bus.calculated, bus.stored} !== 2'b01) begin failures++; $display("FAIL load_stored: got %b, want 01", {bus.calculated, bus.stored}); end
    phase(S_SHOW, 1);
    checks++;
    if (bus.stored !== 1'b0 || bus.result !== 16'h0019) begin
      failures++; $display("FAIL load_show: got stored %b result %h, want 0 0019", bus.stored, bus.result);
    end
    run_instr(DISP, 4'd3, 4'd0, 4'd0, 1'b0, 6'd0);
    checks++;
    if (bus.v1_ram !== 16'd25) begin failures++; $display("FAIL load_mem_r3: got %h, want 0019", bus.v1_ram); end
    run_instr(LOAD, 4'd12, 4'd0, 4'd0, 1'b1, 6'd0);
    checks++;
    if (bus.result !== 16'h0000) begin failures++; $display("FAIL load_neg_zero: got %h, want 0000", bus.result); end
    run_instr(LOAD, 4'd12, 4'd0, 4'd0, 1'b1, 6'd63);
    checks++;
    if (bus.result !== 16'hFFC1) begin failures++; $display("FAIL load_neg63: got %h, want ffc1", bus.result); end
  endtask

  task automatic test_add_display;
    run_instr(LOAD, 4'd1, 4'd0, 4'd0, 1'b0, 6'd5);
    run_instr(LOAD, 4'd2, 4'd0, 4'd0, 1'b0, 6'd7);
    run_instr(ADD, 4'd4, 4'd1, 4'd2, 1'b0, 6'd0);
    checks++;
    if (bus.result !== 16'd12) begin failures++; $display("FAIL add_result: got %h, want 000c", bus.result); end
    run_instr(DISP, 4'd4, 4'd9, 4'd9, 1'b0, 6'd0);
    checks++;
    if (bus.v1_ram !== 16'd12 || bus.v2_ram !== 16'd0 || bus.result !== 16'd12) begin
      failures++; $display("FAIL display_r4: got v1 %h v2 %h res %h, want 000c 0000 000c", bus.v1_ram, bus.v2_ram, bus.result);
    end
    run_instr(DISP, 4'd1, 4'd0, 4'd0, 1'b0, 6'd0);
    checks++;
    if (bus.v1_ram !== 16'd5) begin failures++; $display("FAIL display_keeps_r1: got %h, want 0005", bus.v1_ram); end
  endtask

  task automatic test_sub;
    run_instr(LOAD, 4'd1, 4'd0, 4'd0, 1'b0, 6'd3);
    run_instr(SUBI, 4'd5, 4'd1, 4'd0, 1'b1, 6'd4);
    checks++;
    if (bus.result !== 16'd7) begin failures++; $display("FAIL subi_result: got %h, want 0007", bus.result); end
    run_instr(LOAD, 4'd2, 4'd0, 4'd0, 1'b0, 6'd7);
    run_instr(SUB, 4'd6, 4'd1, 4'd2, 1'b0, 6'd0);
    checks++;
    if (bus.result !== 16'hFFFC) begin failures++; $display("FAIL sub_result: got %h, want fffc", bus.result); end
    run_instr(DISP, 4'd6, 4'd0, 4'd0, 1'b0, 6'd0);
    checks++;
    if (bus.v1_ram !== 16'hFFFC) begin failures++; $display("FAIL sub_mem_r6: got %h, want fffc", bus.v1_ram); end
  endtask

  task automatic test_hold;
    run_instr(LOAD, 4'd9, 4'd0, 4'd0, 1'b0, 6'd10);
    run_instr(LOAD, 4'd13, 4'd0, 4'd0, 1'b0, 6'd1);
    set_fields(ADDI, 4'd9, 4'd9, 4'd0, 1'b0, 6'd5);
    phase(S_FETCH, 1);
    phase(S_DECODE, 1);
    phase(S_READ, 1);
    bus.addr2 = 4'd13;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.v1_ram !== 16'd10) begin failures++; $display("FAIL hold_read: got %h, want 000a", bus.v1_ram); end
    phase(S_CALC, 1);
    bus.imm = 6'd20;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.result !== 16'd15 || bus.calculated !== 1'b1) begin
      failures++; $display("FAIL hold_calc: got result %h flag %b, want 000f 1", bus.result, bus.calculated);
    end
    phase(S_STORE, 1);
    bus.addr1 = 4'd13;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.stored !== 1'b1) begin failures++; $display("FAIL hold_stored: got %b, want 1", bus.stored); end
    run_instr(DISP, 4'd13, 4'd0, 4'd0, 1'b0, 6'd0);
    checks++;
    if (bus.v1_ram !== 16'd1) begin failures++; $display("FAIL hold_store_once_r13: got %h, want 0001", bus.v1_ram); end
    run_instr(DISP, 4'd9, 4'd0, 4'd0, 1'b0, 6'd0);
    checks++;
    if (bus.v1_ram !== 16'd15) begin failures++; $display("FAIL hold_r9: got %h, want 000f", bus.v1_ram); end
    phase(3'b111, 2);
    checks++;
    if ({bus.decoded, bus.read, bus.calculated, bus.stored} !== 4'b0000 || bus.result !== 16'd15) begin
      failures++; $display("FAIL state7_as_off: got flags %b result %h, want 0000 000f",
                           {bus.decoded, bus.read, bus.calculated, bus.stored}, bus.result);
    end
  endtask

  task automatic test_clear;
    for (int i = 0; i < 16; i++) run_instr(LOAD, 4'(i), 4'd0, 4'd0, 1'b0, 6'(i + 1));
    run_instr(DISP, 4'd15, 4'd0, 4'd0, 1'b0, 6'd0);
    checks++;
    if (bus.v1_ram !== 16'd16) begin failures++; $display("FAIL clear_prefill_r15: got %h, want 0010", bus.v1_ram); end
    run_instr(CLEAR, 4'd0, 4'd0, 4'd0, 1'b0, 6'd0);
    for (int i = 0; i < 16; i++) begin
      run_instr(DISP, 4'(i), 4'd0, 4'd0, 1'b0, 6'd0);
      checks++;
      if (bus.v1_ram !== 16'd0) begin failures++; $display("FAIL clear_r%0d: got %h, want 0000", i, bus.v1_ram); end
    end
  endtask

  task automatic test_mul;
    logic [15:0] exp_r7;
    logic [15:0] exp_small;
`ifdef DATAPATH_MUL_EN
    exp_r7    = 16'd0;
    exp_small = 16'd35;
`else
    exp_r7    = 16'd9;
    exp_small = 16'd0;
`endif
    run_instr(LOAD, 4'd0, 4'd0, 4'd0, 1'b0, 6'd0);
    run_instr(LOAD, 4'd1, 4'd0, 4'd0, 1'b0, 6'd32);
    repeat (3) run_instr(ADD, 4'd1, 4'd1, 4'd1, 1'b0, 6'd0);
    run_instr(ADD, 4'd2, 4'd1, 4'd0, 1'b0, 6'd0);
    checks++;
    if (bus.result !== 16'h0100) begin failures++; $display("FAIL mul_setup_r2: got %h, want 0100", bus.result); end
    run_instr(LOAD, 4'd7, 4'd0, 4'd0, 1'b0, 6'd9);
    run_instr(MUL, 4'd7, 4'd1, 4'd2, 1'b0, 6'd0);
    checks++;
    if (bus.result !== 16'h0000 || bus.stored !== 1'b1) begin
      failures++; $display("FAIL mul_wrap: got result %h stored %b, want 0000 1", bus.result, bus.stored);
    end
    run_instr(DISP, 4'd7, 4'd0, 4'd0, 1'b0, 6'd0);
    checks++;
    if (bus.v1_ram !== exp_r7) begin failures++; $display("FAIL mul_mem_r7: got %h, want %h", bus.v1_ram, exp_r7); end
    run_instr(LOAD, 4'd3, 4'd0, 4'd0, 1'b0, 6'd5);
    run_instr(LOAD, 4'd4, 4'd0, 4'd0, 1'b0, 6'd7);
    run_instr(MUL, 4'd8, 4'd3, 4'd4, 1'b0, 6'd0);
    checks++;
    if (bus.result !== exp_small) begin failures++; $display("FAIL mul_small: got %h, want %h", bus.result, exp_small); end
  endtask

  task automatic test_reset_mid;
    run_instr(LOAD, 4'd1, 4'd0, 4'd0, 1'b0, 6'd5);
    run_instr(LOAD, 4'd2, 4'd0, 4'd0, 1'b0, 6'd7);
    set_fields(ADD, 4'd11, 4'd1, 4'd2, 1'b0, 6'd0);
    phase(S_FETCH, 1);
    phase(S_DECODE, 1);
    phase(S_READ, 1);
    phase(S_CALC, 1);
    checks++;
    if (bus.result !== 16'd12) begin failures++; $display("FAIL midrst_pre: got %h, want 000c", bus.result); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.v1_ram, bus.v2_ram, bus.result, bus.decoded, bus.read, bus.calculated, bus.stored} !== 52'd0) begin
      failures++; $display("FAIL midrst_outputs: got %h %h %h %b, want all zero", bus.v1_ram, bus.v2_ram, bus.result,
                           {bus.decoded, bus.read, bus.calculated, bus.stored});
    end
    @(negedge clk);
    bus.state_cpu = S_OFF;
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(DISP, 4'd11, 4'd0, 4'd0, 1'b0, 6'd0);
    checks++;
    if (bus.v1_ram !== 16'd0) begin failures++; $display("FAIL midrst_r11: got %h, want 0000", bus.v1_ram); end
    run_instr(DISP, 4'd1, 4'd0, 4'd0, 1'b0, 6'd0);
    checks++;
    if (bus.v1_ram !== 16'd0) begin failures++; $display("FAIL midrst_r1: got %h, want 0000", bus.v1_ram); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.state_cpu = S_OFF;
    set_fields(LOAD, 4'd0, 4'd0, 4'd0, 1'b0, 6'd0);
    test_reset;
    test_load;
    test_add_display;
    test_sub;
    test_hold;
    test_clear;
    test_mul;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mini_cpu_datapath.md
MINI_CPU_DATAPATH -- requirements
Module: mini_cpu_datapath

Interface
REQ-001 Reset is asynchronous and active-low; the block has one clock.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 state_cpu  in  3  CPU state:
  - OFF=000, FETCH=001, DECODE=010, READ=011, CALC=100, SHOW=101, STORE=110.
REQ-005 opcode  in  3  operation code:
  - LOAD=000, ADD=001, ADDI=010, SUB=011, SUBI=100, MUL=101, CLEAR=110, DISPLAY=111.
REQ-006 addr1  in  4  destination register; source register for DISPLAY.
REQ-007 addr2  in  4  first source register.
REQ-008 addr3  in  4  second source register.
REQ-009 sinal_imm  in  1  immediate sign, 1 = negative.
REQ-010 imm  in  6  immediate magnitude.
REQ-011 v1_ram, v2_ram  out  16 each  registered operand read-outs.
REQ-012 result  out  16  registered ALU result.
REQ-013 decoded, read, calculated, stored  out  1 each  phase-done flags.

Function
REQ-014 Storage: 16 x 16-bit register file, all entries writable; no hardwired zero register.
REQ-015 Immediate: imm_val = sinal_imm ? -imm : +imm, sign-extended to 16 bits; -0 = 0.
REQ-016 DECODE: decoded = 1 from the first rising edge with state_cpu == DECODE; cleared on the first edge with any other state.
REQ-017 READ, non-DISPLAY opcodes: at the first edge, v1_ram <= mem[addr2] and v2_ram <= mem[addr3].
REQ-018 READ, DISPLAY: at the first edge, v1_ram <= mem[addr1] and v2_ram <= 0.
REQ-019 read = 1 from that same edge while state_cpu == READ; cleared otherwise.
REQ-020 CALC, at the first edge, result <= per opcode:
  - LOAD: imm_val
  - ADD: v1+v2
  - ADDI: v1+imm_val
  - SUB: v1-v2
  - SUBI: v1-imm_val
  - MUL: low 16 bits of v1*v2
  - CLEAR: 0
  - DISPLAY: v1
REQ-021 calculated = 1 from that same edge while state_cpu == CALC; cleared otherwise.
REQ-022 Arithmetic is 16-bit two's complement; overflow wraps modulo 2^16 with no flag.
REQ-023 STORE, at the first edge:
  - LOAD/ADD/ADDI/SUB/SUBI/MUL: mem[addr1] <= result.
  - CLEAR: all 16 entries <= 0.
  - DISPLAY: no write.
REQ-024 stored = 1 from that same edge while state_cpu == STORE; cleared otherwise.
REQ-025 Each phase action executes exactly once per state visit, even when the state is held for several cycles.
REQ-026 OFF, FETCH, SHOW: no memory write; all flags 0; v1_ram, v2_ram and result hold their values.
REQ-027 Inputs are sampled at the edge where the action executes; input changes during other states have no effect.
REQ-028 Write followed by read of the same address in the next instruction returns the new value; no same-cycle bypass is needed.
REQ-029 A state_cpu value of 111 is treated as OFF.

Reset
REQ-030 rst_n = 0 immediately clears all 16 memory entries, v1_ram, v2_ram, result and all four flags, independent of clk.
REQ-031 Reset asserted mid-operation aborts the operation; no partial write survives.
REQ-032 After rst_n deasserts, normal operation resumes on the next rising edge.

Configuration
REQ-033 Macro DATAPATH_MUL_EN:
  - Defined: MUL behaves per REQ-020 and REQ-023.
  - Undefined: MUL produces result = 0, STORE performs no write, and stored is still asserted so the handshake completes; no multiplier is synthesised.

Verification
REQ-034 LOAD addr1=3, sinal_imm=0, imm=25 through DECODE..STORE -> result=0x0019, mem[3]=25, each flag high one edge after entering its state.
REQ-035 LOAD r1=5, LOAD r2=7, then ADD addr1=4, addr2=1, addr3=2 -> result=12; DISPLAY addr1=4 -> v1_ram=12, result=12, mem unchanged.
REQ-036 r1=3, SUBI addr1=5, addr2=1, sinal_imm=1, imm=4 -> result=7; SUB r6=r1-r2 with r2=7 -> 0xFFFC.
REQ-037 r1=0x0100, r2=0x0100, MUL -> result=0x0000 (wrap); with DATAPATH_MUL_EN undefined -> result=0, mem unchanged, stored=1.
REQ-038 Fill r0..r15 nonzero, CLEAR -> all entries read 0.
REQ-039 Pulse rst_n low during CALC of ADD -> all outputs and memory 0 immediately; destination entry stays 0.
